// File: rtl/jk_mod_counter.sv
// Modulo-N up/down/complement counter steered by JK-style j/k controls,
// with enable, sync clear, clamped parallel load and a registered wrap pulse.
module jk_mod_counter #(
  parameter int WIDTH  = 2,
  parameter int MODULO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             j,
  input  logic             k,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  if (MODULO < 2) begin : g_bad_mod
    $error("jk_mod_counter: MODULO must be at least 2");
  end
  if ((2 ** WIDTH) < MODULO) begin : g_bad_width
    $error("jk_mod_counter: WIDTH too small for MODULO");
  end

  localparam int MAXI = MODULO - 1;
  localparam logic [WIDTH:0]   MOD_E = MODULO[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_W = MAXI[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  logic             sel_clr, sel_load;
  logic             sel_up, sel_dn, sel_cp;
  logic [WIDTH:0]   up_e;
  logic             wrap_up, wrap_dn;

  // Mask lower-priority selects so the decoder sees a one-hot set
  assign sel_clr  = clr;
  assign sel_load = load & ~clr;
  assign sel_up   = en & ~clr & ~load & j & ~k;
  assign sel_dn   = en & ~clr & ~load & ~j & k;
  assign sel_cp   = en & ~clr & ~load & j & k;

  assign up_e    = {1'b0, count_q} + 1'b1;
  assign wrap_up = (up_e == MOD_E);
  assign wrap_dn = (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    unique case (1'b1)
      sel_clr:  count_d = '0;
      sel_load: count_d = (load_val > MAX_W) ? MAX_W : load_val;
      sel_up: begin
        count_d = wrap_up ? '0 : up_e[WIDTH-1:0];
        tc_d    = wrap_up;
      end
      sel_dn: begin
        count_d = wrap_dn ? MAX_W : count_q - 1'b1;
        tc_d    = wrap_dn;
      end
      sel_cp:   count_d = MAX_W - count_q;
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed scoreboard bench for jk_mod_counter: a default 0..3 instance
// and a MODULO=5/WIDTH=3 instance share clock and reset.
module tb_jk_mod_counter;

  typedef struct {
    logic [2:0] c;
    logic       t;
    string      tag;
  } exp_t;

  logic clk, rst_n;

  logic       en4, j4, k4, clr4, ld4, tc4;
  logic [1:0] lv4, cnt4;
  logic       en5, j5, k5, clr5, ld5, tc5;
  logic [2:0] lv5, cnt5;

  exp_t q4[$];
  exp_t q5[$];
  int checks = 0;
  int errors = 0;

  jk_mod_counter u_d4 (
    .clk(clk), .rst(rst_n), .en(en4), .j(j4), .k(k4),
    .clr(clr4), .load(ld4), .load_val(lv4),
    .count(cnt4), .tc(tc4)
  );

  jk_mod_counter #(.WIDTH(3), .MODULO(5)) u_d5 (
    .clk(clk), .rst(rst_n), .en(en5), .j(j5), .k(k5),
    .clr(clr5), .load(ld5), .load_val(lv5),
    .count(cnt5), .tc(tc5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs_c,
                     input logic obs_t, input logic [2:0] exp_c,
                     input logic exp_t);
    checks++;
    assert (obs_c === exp_c && obs_t === exp_t) else begin
      errors++;
      $error("FAIL %s: count=%0d tc=%0b expected count=%0d tc=%0b",
             tag, obs_c, obs_t, exp_c, exp_t);
    end
  endtask

  task automatic step4(input logic e, input logic jj, input logic kk,
                       input logic c, input logic l, input logic [1:0] v,
                       input logic [2:0] ec, input logic et,
                       input string tag);
    exp_t x;
    en4 = e; j4 = jj; k4 = kk; clr4 = c; ld4 = l; lv4 = v;
    q4.push_back('{ec, et, tag});
    @(posedge clk);
    #1;
    x = q4.pop_front();
    chk(x.tag, {1'b0, cnt4}, tc4, x.c, x.t);
  endtask

  task automatic step5(input logic e, input logic jj, input logic kk,
                       input logic c, input logic l, input logic [2:0] v,
                       input logic [2:0] ec, input logic et,
                       input string tag);
    exp_t x;
    en5 = e; j5 = jj; k5 = kk; clr5 = c; ld5 = l; lv5 = v;
    q5.push_back('{ec, et, tag});
    @(posedge clk);
    #1;
    x = q5.pop_front();
    chk(x.tag, cnt5, tc5, x.c, x.t);
  endtask

  initial begin
    rst_n = 1'b0;
    {en4, j4, k4, clr4, ld4} = '0; lv4 = '0;
    {en5, j5, k5, clr5, ld5} = '0; lv5 = '0;
    #3;
    chk("rst4", {1'b0, cnt4}, tc4, 3'd0, 1'b0);
    chk("rst5", cnt5, tc5, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // up wrap 0..3 on defaults
    step4(1, 1, 0, 0, 0, 2'd0, 3'd1, 0, "up1");
    step4(1, 1, 0, 0, 0, 2'd0, 3'd2, 0, "up2");
    step4(1, 1, 0, 0, 0, 2'd0, 3'd3, 0, "up3");
    step4(1, 1, 0, 0, 0, 2'd0, 3'd0, 1, "upwrap");
    step4(1, 1, 0, 0, 0, 2'd0, 3'd1, 0, "up_after");
    step4(1, 1, 0, 0, 0, 2'd0, 3'd2, 0, "up_mid");

    // async reset mid-count, no edge needed
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {1'b0, cnt4}, tc4, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold", {1'b0, cnt4}, tc4, 3'd0, 1'b0);
    rst_n = 1'b1;
    step4(1, 1, 0, 0, 0, 2'd0, 3'd1, 0, "post_rst");

    // complement and hold
    step4(0, 0, 0, 0, 1, 2'd1, 3'd1, 0, "load1");
    step4(1, 1, 1, 0, 0, 2'd0, 3'd2, 0, "comp_a");
    step4(1, 1, 1, 0, 0, 2'd0, 3'd1, 0, "comp_b");
    step4(1, 0, 0, 0, 0, 2'd0, 3'd1, 0, "hold1");
    step4(1, 0, 0, 0, 0, 2'd0, 3'd1, 0, "hold2");
    step4(1, 0, 0, 0, 0, 2'd0, 3'd1, 0, "hold3");
    step4(0, 1, 0, 0, 0, 2'd0, 3'd1, 0, "en_off");

    // down wrap on defaults
    step4(0, 0, 0, 1, 0, 2'd0, 3'd0, 0, "clr4");
    step4(1, 0, 1, 0, 0, 2'd0, 3'd3, 1, "dnwrap4");
    step4(1, 0, 1, 0, 0, 2'd0, 3'd2, 0, "dn4");

    // en toggling
    step4(0, 0, 0, 1, 0, 2'd0, 3'd0, 0, "clr4b");
    step4(1, 1, 0, 0, 0, 2'd0, 3'd1, 0, "ent1");
    step4(0, 1, 0, 0, 0, 2'd0, 3'd1, 0, "ent0");
    step4(1, 1, 0, 0, 0, 2'd0, 3'd2, 0, "ent2");
    step4(1, 1, 0, 0, 0, 2'd0, 3'd3, 0, "ent3");

    // MODULO=5 down wrap
    step5(1, 0, 1, 0, 0, 3'd0, 3'd4, 1, "dnwrap5");
    step5(1, 0, 1, 0, 0, 3'd0, 3'd3, 0, "dn5a");
    step5(1, 0, 1, 0, 0, 3'd0, 3'd2, 0, "dn5b");

    // priority and clamp
    step5(0, 0, 0, 0, 1, 3'd7, 3'd4, 0, "clamp7");
    step5(1, 1, 0, 1, 1, 3'd3, 3'd0, 0, "clr_wins");
    step5(1, 1, 0, 0, 1, 3'd4, 3'd4, 0, "load_wins");
    step5(1, 1, 0, 0, 0, 3'd0, 3'd0, 1, "upwrap5");
    step5(1, 1, 0, 0, 0, 3'd0, 3'd1, 0, "up5");
    step5(1, 1, 1, 0, 0, 3'd0, 3'd3, 0, "comp5");
    step5(0, 0, 0, 0, 1, 3'd5, 3'd4, 0, "clamp5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
